// File: rtl/voice_read_arbiter.sv
// rtl/voice_read_arbiter.sv - round-robin voice read arbiter with credit limit and deadline-miss flags
module voice_read_arbiter #(
  parameter int NUM_VOICES      = 8,
  parameter int MAX_OUTSTANDING = 4,
  parameter int TAG_W           = $clog2(NUM_VOICES),
  localparam int CNT_W          = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_VOICES*24-1:0] voice_addr,
  input  logic [NUM_VOICES-1:0]    voice_addr_valid,
  output logic [NUM_VOICES-1:0]    voice_addr_ready,
  input  logic                     sample_tick,
  output logic [23:0]              dram_addr,
  output logic [TAG_W-1:0]         dram_tag,
  output logic                     dram_valid,
  input  logic                     dram_ready,
  input  logic                     dram_resp_valid,
  output logic [CNT_W-1:0]         outstanding,
  output logic [NUM_VOICES-1:0]    miss_flags,
  input  logic                     miss_clear
);

  logic [23:0]            dram_addr_q, dram_addr_d;
  logic [TAG_W-1:0]       dram_tag_q, dram_tag_d;
  logic                   dram_valid_q, dram_valid_d;
  logic [TAG_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]       out_q, out_d;
  logic [NUM_VOICES-1:0]  age_q, age_d;
  logic [NUM_VOICES-1:0]  miss_q, miss_d;

  logic                   slot_free;
  logic                   grant_en;
  logic                   win_found;
  logic [TAG_W-1:0]       win_idx;
  logic                   grant;
  logic                   resp_dec;
  logic [NUM_VOICES-1:0]  grant_vec;
  logic [NUM_VOICES-1:0]  new_miss;
  int                     idx;

  // Rotating priority search starting at rr_ptr, wrapping past the last voice.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    idx       = 0;
    for (int k = 0; k < NUM_VOICES; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NUM_VOICES) idx = idx - NUM_VOICES;
      if (!win_found && voice_addr_valid[idx]) begin
        win_found = 1'b1;
        win_idx   = TAG_W'(idx);
      end
    end
  end

  // Responses arriving this cycle are not credited until the count updates.
  assign slot_free = !dram_valid_q || dram_ready;
  assign grant_en  = slot_free && (out_q < CNT_W'(MAX_OUTSTANDING));
  assign grant     = rst_n && grant_en && win_found;
  assign grant_vec = grant ? (NUM_VOICES'(1) << win_idx) : '0;
  assign resp_dec  = dram_resp_valid && (out_q != '0);

  always_comb begin
    dram_addr_d  = dram_addr_q;
    dram_tag_d   = dram_tag_q;
    dram_valid_d = dram_valid_q;
    rr_ptr_d     = rr_ptr_q;
    if (grant) begin
      dram_addr_d  = voice_addr[int'(win_idx)*24 +: 24];
      dram_tag_d   = win_idx;
      dram_valid_d = 1'b1;
      rr_ptr_d     = (int'(win_idx) == NUM_VOICES - 1) ? '0 : win_idx + 1'b1;
    end else if (dram_ready) begin
      dram_valid_d = 1'b0;
    end
  end

  always_comb begin
    out_d = out_q;
    case ({grant, resp_dec})
      2'b10:   out_d = out_q + 1'b1;
      2'b01:   out_d = out_q - 1'b1;
      default: out_d = out_q;
    endcase
  end

  // A voice misses when it is still waiting at the second tick of its wait.
  always_comb begin
    new_miss = '0;
    age_d    = age_q & voice_addr_valid & ~grant_vec;
    if (sample_tick) begin
      new_miss = age_q & voice_addr_valid & ~grant_vec;
      age_d    = voice_addr_valid & ~grant_vec;
    end
    miss_d = (miss_clear ? '0 : miss_q) | new_miss;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dram_addr_q  <= '0;
      dram_tag_q   <= '0;
      dram_valid_q <= 1'b0;
      rr_ptr_q     <= '0;
      out_q        <= '0;
      age_q        <= '0;
      miss_q       <= '0;
    end else begin
      dram_addr_q  <= dram_addr_d;
      dram_tag_q   <= dram_tag_d;
      dram_valid_q <= dram_valid_d;
      rr_ptr_q     <= rr_ptr_d;
      out_q        <= out_d;
      age_q        <= age_d;
      miss_q       <= miss_d;
    end
  end

  assign voice_addr_ready = grant_vec;
  assign dram_addr        = dram_addr_q;
  assign dram_tag         = dram_tag_q;
  assign dram_valid       = dram_valid_q;
  assign outstanding      = out_q;
  assign miss_flags       = miss_q;

endmodule

// File: tb/tb_voice_read_arbiter.sv
// tb/tb_voice_read_arbiter.sv - scoreboard bench for voice_read_arbiter
module tb_voice_read_arbiter;

  localparam int NV = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [NV*24-1:0] voice_addr = '0;
  logic [NV-1:0] voice_addr_valid = '0;
  logic [NV-1:0] voice_addr_ready;
  logic          sample_tick = 1'b0;
  logic [23:0]   dram_addr;
  logic [2:0]    dram_tag;
  logic          dram_valid;
  logic          dram_ready = 1'b0;
  logic          dram_resp_valid = 1'b0;
  logic [2:0]    outstanding;
  logic [NV-1:0] miss_flags;
  logic          miss_clear = 1'b0;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  voice_read_arbiter #(.NUM_VOICES(8), .MAX_OUTSTANDING(4)) dut (
    .clk(clk), .rst_n(rst_n), .voice_addr(voice_addr),
    .voice_addr_valid(voice_addr_valid), .voice_addr_ready(voice_addr_ready),
    .sample_tick(sample_tick), .dram_addr(dram_addr), .dram_tag(dram_tag),
    .dram_valid(dram_valid), .dram_ready(dram_ready),
    .dram_resp_valid(dram_resp_valid), .outstanding(outstanding),
    .miss_flags(miss_flags), .miss_clear(miss_clear)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int tag, input logic [23:0] addr);
    exp_q.push_back({8'(tag), addr});
  endtask

  task automatic load_table();
    for (int i = 0; i < NV; i++) voice_addr[i*24 +: 24] = 24'h100000 | 24'(i);
  endtask

  // Every accepted DRAM request must match the oldest predicted grant.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && dram_valid === 1'b1 && dram_ready === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL dram_xfer actual=%h required=none", {8'(dram_tag), dram_addr});
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if ({8'(dram_tag), dram_addr} !== e) begin
          errors++;
          $display("FAIL dram_xfer actual=%h required=%h", {8'(dram_tag), dram_addr}, e);
        end
      end
    end
  end

  initial begin
    #1 rst_n = 1'b0;
    voice_addr_valid = 8'hFF;
    #2;
    chk("rst_valid", 32'(dram_valid), 0);
    chk("rst_addr", 32'(dram_addr), 0);
    chk("rst_tag", 32'(dram_tag), 0);
    chk("rst_out", 32'(outstanding), 0);
    chk("rst_miss", 32'(miss_flags), 0);
    chk("rst_ready", 32'(voice_addr_ready), 0);
    voice_addr_valid = '0;
    nxt(); nxt();
    rst_n = 1'b1;

    // single request
    nxt();
    voice_addr[3*24 +: 24] = 24'h001234;
    voice_addr_valid = 8'h08;
    dram_ready = 1'b1;
    #1 chk("single_ready", 32'(voice_addr_ready), 32'h08);
    push(3, 24'h001234);
    nxt(); voice_addr_valid = '0;
    #1 chk("single_valid", 32'(dram_valid), 1);
    chk("single_addr", 32'(dram_addr), 32'h001234);
    chk("single_tag", 32'(dram_tag), 3);
    chk("single_out", 32'(outstanding), 1);
    nxt(); dram_resp_valid = 1'b1;
    #1 chk("single_drop", 32'(dram_valid), 0);
    nxt();
    #1 chk("resp_out", 32'(outstanding), 0);
    nxt(); dram_resp_valid = 1'b0;
    #1 chk("stray_out", 32'(outstanding), 0);

    // fresh pointer for the rotation test
    rst_n = 1'b0;
    nxt(); rst_n = 1'b1;
    load_table();

    // round robin with a three-cycle stall
    nxt(); voice_addr_valid = 8'hFF; dram_ready = 1'b0;
    #1 chk("rr_g0", 32'(voice_addr_ready), 32'h01);
    push(0, 24'h100000);
    for (int s = 0; s < 3; s++) begin
      nxt();
      #1 chk("stall_ready", 32'(voice_addr_ready), 0);
      chk("stall_tag", 32'(dram_tag), 0);
      chk("stall_addr", 32'(dram_addr), 32'h100000);
    end
    dram_ready = 1'b1;
    for (int g = 1; g <= 3; g++) begin
      if (g > 1) nxt();
      #1 chk("rr_grant", 32'(voice_addr_ready), 32'h1 << g);
      push(g, 24'h100000 | 24'(g));
    end
    nxt();
    #1 chk("cap_ready", 32'(voice_addr_ready), 0);
    chk("cap_out", 32'(outstanding), 4);
    nxt(); dram_resp_valid = 1'b1;
    #1 chk("cap_nocredit", 32'(voice_addr_ready), 0);
    chk("cap_dv", 32'(dram_valid), 0);

    // credit return
    nxt(); dram_resp_valid = 1'b0;
    #1 chk("credit_out", 32'(outstanding), 3);
    chk("credit_g4", 32'(voice_addr_ready), 32'h10);
    push(4, 24'h100004);
    nxt(); dram_resp_valid = 1'b1;
    #1 chk("credit_out4", 32'(outstanding), 4);
    chk("credit_tag", 32'(dram_tag), 4);

    // simultaneous grant and response
    nxt();
    #1 chk("sim_g5", 32'(voice_addr_ready), 32'h20);
    chk("sim_out_before", 32'(outstanding), 3);
    push(5, 24'h100005);
    nxt(); dram_resp_valid = 1'b0;
    #1 chk("sim_out_after", 32'(outstanding), 3);
    chk("sim_g6", 32'(voice_addr_ready), 32'h40);
    push(6, 24'h100006);

    // deadline miss on voice 5 with credits exhausted
    nxt(); voice_addr_valid = 8'h20; sample_tick = 1'b1;
    #1 chk("miss_out", 32'(outstanding), 4);
    chk("miss_noready", 32'(voice_addr_ready), 0);
    nxt(); sample_tick = 1'b0;
    #1 chk("miss_first", 32'(miss_flags), 0);
    nxt(); sample_tick = 1'b1;
    nxt(); sample_tick = 1'b0;
    #1 chk("miss_second", 32'(miss_flags), 32'h20);
    miss_clear = 1'b1;
    nxt(); miss_clear = 1'b0;
    #1 chk("miss_cleared", 32'(miss_flags), 0);
    miss_clear = 1'b1; sample_tick = 1'b1;
    nxt(); miss_clear = 1'b0; sample_tick = 1'b0;
    #1 chk("miss_clear_race", 32'(miss_flags), 32'h20);

    // drain to two in flight, then reset with a pending request
    voice_addr_valid = '0; dram_resp_valid = 1'b1;
    nxt();
    nxt();
    #1 chk("drain_out", 32'(outstanding), 2);
    voice_addr_valid = 8'h04; dram_ready = 1'b0;
    #1 chk("pre_rst_g2", 32'(voice_addr_ready), 32'h04);
    nxt(); voice_addr_valid = 8'hFF; dram_resp_valid = 1'b0;
    #1 chk("pre_rst_out", 32'(outstanding), 2);
    chk("pre_rst_dv", 32'(dram_valid), 1);
    chk("pre_rst_tag", 32'(dram_tag), 2);
    rst_n = 1'b0; dram_resp_valid = 1'b1;
    #1 chk("arst_dv", 32'(dram_valid), 0);
    chk("arst_addr", 32'(dram_addr), 0);
    chk("arst_tag", 32'(dram_tag), 0);
    chk("arst_out", 32'(outstanding), 0);
    chk("arst_miss", 32'(miss_flags), 0);
    chk("arst_ready", 32'(voice_addr_ready), 0);
    nxt(); rst_n = 1'b1; dram_ready = 1'b1;
    #1 chk("post_rst_g0", 32'(voice_addr_ready), 32'h01);
    push(0, 24'h100000);
    nxt(); voice_addr_valid = '0; dram_resp_valid = 1'b0;
    #1 chk("post_rst_out", 32'(outstanding), 1);
    chk("post_rst_tag", 32'(dram_tag), 0);
    nxt(); nxt();
    chk("sb_empty", 32'(exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
